// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the multi-phase traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } phase_state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

endpackage

// File: rtl/phase_rr_arbiter.sv
// Combinational round-robin picker: first pending phase strictly after
// active_phase, wrapping, with active_phase itself considered last.
module phase_rr_arbiter #(
  parameter int NUM_PHASES = 4,
  parameter int PW         = $clog2(NUM_PHASES)
) (
  input  logic [NUM_PHASES-1:0] pending,
  input  logic [PW-1:0]         active_phase,
  output logic [PW-1:0]         next_phase,
  output logic                  any_pending
);

  localparam logic [PW:0] NUM_W = (PW+1)'(NUM_PHASES);

  logic [PW:0]           shamt;
  logic [NUM_PHASES-1:0] rot;
  logic [NUM_PHASES-1:0] first;
  logic [PW-1:0]         offset;
  logic [PW:0]           sum;
  logic [PW:0]           wrapped;

  // rot[k] holds pending[(active_phase + 1 + k) mod NUM_PHASES]
  assign shamt = {1'b0, active_phase} + (PW+1)'(1);
  assign rot   = NUM_PHASES'({pending, pending} >> shamt);
  assign first = rot & (-rot);

  for (genvar gb = 0; gb < PW; gb++) begin : g_enc
    logic [NUM_PHASES-1:0] sel_mask;
    for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_bit
      assign sel_mask[gi] = ((gi >> gb) & 1) != 0;
    end
    assign offset[gb] = |(first & sel_mask);
  end

  assign sum         = shamt + {1'b0, offset};
  assign wrapped     = (sum >= NUM_W) ? sum - NUM_W : sum;
  assign next_phase  = wrapped[PW-1:0];
  assign any_pending = |pending;

endmodule

// File: rtl/traffic_phase_controller.sv
// Demand-actuated multi-phase intersection controller with green extension,
// pedestrian walk, all-red clearance and night-flash mode.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int TIMER_W      = 8,
  parameter int GREEN_MIN    = 8,
  parameter int GREEN_MAX    = 20,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 6,
  parameter int FLASH_HALF   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PHASES-1:0]         demand,
  input  logic [NUM_PHASES-1:0]         ped_req,
  input  logic                          flash,
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [NUM_PHASES-1:0]         walk,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic                          in_flash
);

  localparam int PW      = $clog2(NUM_PHASES);
  localparam int MIN_PED = (WALK_TIME > GREEN_MIN) ? WALK_TIME : GREEN_MIN;

  typedef logic [TIMER_W-1:0] tmr_t;
  localparam tmr_t T_GMIN   = tmr_t'(GREEN_MIN - 1);
  localparam tmr_t T_PMIN   = tmr_t'(MIN_PED - 1);
  localparam tmr_t T_GMAX   = tmr_t'(GREEN_MAX - 1);
  localparam tmr_t T_YEL    = tmr_t'(YELLOW_TIME - 1);
  localparam tmr_t T_AR     = tmr_t'(ALL_RED_TIME - 1);
  localparam tmr_t T_FLASH  = tmr_t'(FLASH_HALF - 1);
  localparam tmr_t T_WALK   = tmr_t'(WALK_TIME);

  phase_state_t          state_reg, state_next;
  tmr_t                  timer_reg, timer_next;
  logic [PW-1:0]         active_reg, active_next;
  logic [NUM_PHASES-1:0] pending_reg, pending_next;
  logic [NUM_PHASES-1:0] ped_pending_reg, ped_pending_next;
  logic                  walk_mode_reg, walk_mode_next;
  logic                  dark_reg, dark_next;
  logic                  restart_reg, restart_next;
  logic [3*NUM_PHASES-1:0] lights_reg, lights_next;
  logic [NUM_PHASES-1:0] walk_reg, walk_next;
  logic                  in_flash_reg;

  logic [PW-1:0]         rr_phase, new_phase;
  logic                  any_pending;
  logic [NUM_PHASES-1:0] is_active, is_new, is_next;
  logic [NUM_PHASES-1:0] req_mask;
  logic                  green_entry;

  phase_rr_arbiter #(
    .NUM_PHASES (NUM_PHASES),
    .PW         (PW)
  ) u_arb (
    .pending      (pending_reg),
    .active_phase (active_reg),
    .next_phase   (rr_phase),
    .any_pending  (any_pending)
  );

  // Leaving flash always restarts at phase 0; otherwise serve demand or rest.
  assign new_phase = restart_reg ? '0 : (any_pending ? rr_phase : active_reg);

  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
    assign is_active[gi] = (active_reg == PW'(gi));
    assign is_new[gi]    = (new_phase == PW'(gi));
    assign is_next[gi]   = (active_next == PW'(gi));
    assign lights_next[3*gi +: 3] =
        (state_next == GREEN  && is_next[gi]) ? LAMP_GREEN  :
        (state_next == YELLOW && is_next[gi]) ? LAMP_YELLOW :
        (state_next == FLASH  && dark_next)   ? LAMP_DARK   : LAMP_RED;
    assign walk_next[gi] = (state_next == GREEN) && is_next[gi] && walk_mode_next &&
                           (timer_next < T_WALK);
  end

  // Requests for the phase currently in green are not latched; demand only extends.
  assign req_mask = (state_reg == GREEN) ? ~is_active : '1;

  always_comb begin
    state_next       = state_reg;
    timer_next       = (timer_reg == '1) ? timer_reg : timer_reg + tmr_t'(1);
    active_next      = active_reg;
    walk_mode_next   = walk_mode_reg;
    dark_next        = dark_reg;
    restart_next     = restart_reg;
    pending_next     = pending_reg | ((demand | ped_req) & req_mask);
    ped_pending_next = ped_pending_reg | (ped_req & req_mask);
    green_entry      = 1'b0;

    case (state_reg)
      ALL_RED: begin
        if (timer_reg >= T_AR) begin
          if (flash) begin
            state_next = FLASH;
            dark_next  = 1'b0;
          end else begin
            green_entry = 1'b1;
          end
        end
      end
      GREEN: begin
        if (flash) begin
          state_next = YELLOW;
        end else if (timer_reg >= (walk_mode_reg ? T_PMIN : T_GMIN) &&
                     |(pending_reg & ~is_active) &&
                     (!(|(demand & is_active)) || timer_reg >= T_GMAX)) begin
          state_next = YELLOW;
        end
      end
      YELLOW: begin
        if (timer_reg >= T_YEL) state_next = ALL_RED;
      end
      FLASH: begin
        if (timer_reg >= T_FLASH) begin
          timer_next = '0;
          if (!flash) begin
            state_next   = ALL_RED;
            restart_next = 1'b1;
          end else begin
            dark_next = ~dark_reg;
          end
        end
      end
      default: state_next = ALL_RED;
    endcase

    if (green_entry) begin
      state_next       = GREEN;
      active_next      = new_phase;
      walk_mode_next   = |((ped_pending_reg | ped_req) & is_new);
      pending_next     = pending_next & ~is_new;
      ped_pending_next = ped_pending_next & ~is_new;
      restart_next     = 1'b0;
    end

    if (state_next != state_reg) timer_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ALL_RED;
      timer_reg       <= '0;
      active_reg      <= '0;
      pending_reg     <= '0;
      ped_pending_reg <= '0;
      walk_mode_reg   <= 1'b0;
      dark_reg        <= 1'b0;
      restart_reg     <= 1'b0;
      lights_reg      <= {NUM_PHASES{LAMP_RED}};
      walk_reg        <= '0;
      in_flash_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      active_reg      <= active_next;
      pending_reg     <= pending_next;
      ped_pending_reg <= ped_pending_next;
      walk_mode_reg   <= walk_mode_next;
      dark_reg        <= dark_next;
      restart_reg     <= restart_next;
      lights_reg      <= lights_next;
      walk_reg        <= walk_next;
      in_flash_reg    <= (state_next == FLASH);
    end
  end

  assign lights       = lights_reg;
  assign walk         = walk_reg;
  assign active_phase = active_reg;
  assign in_flash     = in_flash_reg;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller (default parameters, 4 phases).
module tb_traffic_phase_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  demand;
  logic [3:0]  ped_req;
  logic        flash;
  logic [11:0] lights;
  logic [3:0]  walk;
  logic [1:0]  active_phase;
  logic        in_flash;

  int errors = 0;
  int checks = 0;

  // Lamp patterns, phase 3 in the top bits: {p3,p2,p1,p0}
  localparam logic [11:0] ALL_RED_L = 12'h924;
  localparam logic [11:0] ALL_DARK  = 12'h000;
  localparam logic [11:0] G0        = 12'h921;
  localparam logic [11:0] Y0        = 12'h922;
  localparam logic [11:0] G1        = 12'h90C;
  localparam logic [11:0] Y1        = 12'h914;
  localparam logic [11:0] G2        = 12'h864;
  localparam logic [11:0] Y2        = 12'h8A4;
  localparam logic [11:0] G3        = 12'h324;
  localparam logic [11:0] Y3        = 12'h524;

  traffic_phase_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .demand       (demand),
    .ped_req      (ped_req),
    .flash        (flash),
    .lights       (lights),
    .walk         (walk),
    .active_phase (active_phase),
    .in_flash     (in_flash)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("chk %s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    demand  = '0;
    ped_req = '0;
    flash   = 1'b0;
    tick(3);
    chk("rst_lights", 32'(lights), 32'(ALL_RED_L));
    chk("rst_walk", 32'(walk), 0);
    chk("rst_active", 32'(active_phase), 0);
    chk("rst_in_flash", 32'(in_flash), 0);

    // Startup: two all-red cycles, then phase 0 green; demand[2] at green cycle 0
    reset_n = 1'b1;                                 // N0
    tick(1); chk("start_ar", 32'(lights), 32'(ALL_RED_L));
    tick(1); chk("start_g0", 32'(lights), 32'(G0));  // N2
    chk("start_act0", 32'(active_phase), 0);
    demand[2] = 1'b1;
    tick(1); demand[2] = 1'b0;                      // N3
    tick(6); chk("g0_min_last", 32'(lights), 32'(G0)); // N9
    tick(1); chk("y0_first", 32'(lights), 32'(Y0));    // N10
    tick(2); chk("y0_last", 32'(lights), 32'(Y0));     // N12
    tick(1); chk("ar_first", 32'(lights), 32'(ALL_RED_L));
    tick(1); chk("ar_last", 32'(lights), 32'(ALL_RED_L));
    tick(1); chk("g2_skip1", 32'(lights), 32'(G2));    // N15
    chk("g2_act", 32'(active_phase), 2);

    // Phase 2 rests with no other demand
    tick(15); chk("g2_rest", 32'(lights), 32'(G2));    // N30

    // Max-out: demand[0] held, demand[1] pending
    demand[0] = 1'b1;
    tick(2); chk("y2", 32'(lights), 32'(Y2));          // N32
    demand[1] = 1'b1;
    tick(1); demand[1] = 1'b0;                         // N33
    tick(4); chk("g0_ext_first", 32'(lights), 32'(G0)); // N37
    chk("g0_ext_act", 32'(active_phase), 0);
    tick(19); chk("g0_ext_last", 32'(lights), 32'(G0)); // N56
    tick(1); chk("g0_maxout_y", 32'(lights), 32'(Y0));  // N57
    demand[0] = 1'b0;
    tick(5); chk("g1", 32'(lights), 32'(G1));           // N62
    chk("g1_act", 32'(active_phase), 1);

    // Pedestrian on phase 3 while phase 1 is green
    ped_req[3] = 1'b1;
    tick(1); ped_req[3] = 1'b0;                         // N63
    tick(6); chk("g1_last", 32'(lights), 32'(G1));      // N69
    tick(1); chk("y1", 32'(lights), 32'(Y1));           // N70
    tick(5); chk("g3", 32'(lights), 32'(G3));           // N75
    chk("g3_walk_on", 32'(walk), 32'h8);
    chk("g3_act", 32'(active_phase), 3);
    demand[0] = 1'b1;
    tick(1); demand[0] = 1'b0;                          // N76
    tick(4); chk("g3_walk_last", 32'(walk), 32'h8);     // N80
    tick(1); chk("g3_walk_off", 32'(walk), 0);          // N81
    chk("g3_still", 32'(lights), 32'(G3));
    tick(1); chk("g3_last", 32'(lights), 32'(G3));      // N82
    tick(1); chk("y3", 32'(lights), 32'(Y3));           // N83
    tick(5); chk("g0_after3", 32'(lights), 32'(G0));    // N88

    // Flash mid-green
    tick(2); flash = 1'b1;                              // N90
    tick(1); chk("flash_y0", 32'(lights), 32'(Y0));     // N91
    chk("flash_y0_walk", 32'(walk), 0);
    tick(2); chk("flash_y0_last", 32'(lights), 32'(Y0)); // N93
    tick(1); chk("flash_ar", 32'(lights), 32'(ALL_RED_L));
    tick(1); chk("flash_ar_nf", 32'(in_flash), 0);      // N95
    tick(1); chk("fl_red", 32'(lights), 32'(ALL_RED_L)); // N96
    chk("fl_in_flash", 32'(in_flash), 1);
    tick(1); demand[2] = 1'b1;                          // N97
    tick(1); demand[2] = 1'b0;                          // N98
    tick(1); chk("fl_red_last", 32'(lights), 32'(ALL_RED_L)); // N99
    tick(1); chk("fl_dark", 32'(lights), 32'(ALL_DARK));      // N100
    chk("fl_walk", 32'(walk), 0);
    tick(3); chk("fl_dark_last", 32'(lights), 32'(ALL_DARK)); // N103
    tick(1); chk("fl_red2", 32'(lights), 32'(ALL_RED_L));     // N104
    tick(1); flash = 1'b0;                              // N105
    tick(3); chk("fl_exit_ar", 32'(lights), 32'(ALL_RED_L)); // N108
    chk("fl_exit_nf", 32'(in_flash), 0);
    tick(1); chk("fl_exit_ar2", 32'(lights), 32'(ALL_RED_L));
    tick(1); chk("fl_restart_g0", 32'(lights), 32'(G0)); // N110
    chk("fl_restart_act", 32'(active_phase), 0);
    tick(7); chk("g0_retained_last", 32'(lights), 32'(G0)); // N117
    tick(1); chk("y0_retained", 32'(lights), 32'(Y0));      // N118
    tick(5); chk("g2_retained", 32'(lights), 32'(G2));      // N123
    chk("g2_retained_act", 32'(active_phase), 2);

    // Asynchronous reset mid-yellow
    demand[1] = 1'b1;
    tick(1); demand[1] = 1'b0;                          // N124
    tick(7); chk("y2_pre_rst", 32'(lights), 32'(Y2));   // N131
    #2 reset_n = 1'b0;
    #1;
    chk("arst_lights", 32'(lights), 32'(ALL_RED_L));
    chk("arst_active", 32'(active_phase), 0);
    chk("arst_walk", 32'(walk), 0);
    chk("arst_in_flash", 32'(in_flash), 0);
    tick(1); reset_n = 1'b1;
    tick(1); chk("restart_ar", 32'(lights), 32'(ALL_RED_L));
    tick(1); chk("restart_g0", 32'(lights), 32'(G0));
    chk("restart_act", 32'(active_phase), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
